icache_miss_ctrl: RTL and testbench

- Instruction-cache miss/refill controller in the fetch stage.
- Detects a fetch miss and drives the miss/replacement/redirect signals that the hazard unit consumes: instr_miss_f, instr_cache_rep_en, pc_src_reg.
- Fetches the missing line from the memory side over a request/response handshake and writes it into the cache array word by word.
- Records any branch redirect resolved while the fill is in flight.

---
 rtl/icache_miss_ctrl.sv | 119 +++++++++++
 tb/tb_icache_miss_ctrl.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_miss_ctrl.sv
// Instruction-cache miss/refill controller: detects a fetch miss, requests the
// line from memory, writes it word by word and records any in-flight redirect.
module icache_miss_ctrl #(
  parameter  int WORDS_PER_LINE = 4,
  parameter  int ADDR_WIDTH     = 32,
  parameter  int DATA_WIDTH     = 32,
  localparam int IDX_W          = $clog2(WORDS_PER_LINE),
  localparam int OFF_W          = $clog2(WORDS_PER_LINE * DATA_WIDTH / 8)
) (
  input  logic                  clk_i,
  input  logic                  reset_n_i,
  input  logic [ADDR_WIDTH-1:0] pc_f_i,
  input  logic                  lookup_valid_i,
  input  logic                  lookup_hit_i,
  input  logic [1:0]            pc_src_i,
  output logic                  instr_miss_f_o,
  output logic                  instr_cache_rep_en_o,
  output logic [1:0]            pc_src_reg_o,
  output logic                  mem_req_valid_o,
  input  logic                  mem_req_ready_i,
  output logic [ADDR_WIDTH-1:0] mem_req_addr_o,
  input  logic                  mem_rsp_valid_i,
  input  logic [DATA_WIDTH-1:0] mem_rsp_data_i,
  output logic                  fill_we_o,
  output logic [IDX_W-1:0]      fill_word_idx_o,
  output logic [DATA_WIDTH-1:0] fill_data_o,
  output logic [ADDR_WIDTH-1:0] fill_line_addr_o
);

  // state | meaning
  // IDLE  | lookups are served; a miss latches the line address
  // REQ   | line request presented until memory accepts it
  // FILL  | response beats written into the data array in order
  // DONE  | single tag/valid write cycle, then back to IDLE
  typedef enum logic [1:0] {IDLE, REQ, FILL, DONE} state_t;

  localparam logic [ADDR_WIDTH-1:0] OFF_MASK = ADDR_WIDTH'((64'd1 << OFF_W) - 64'd1);
  localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(WORDS_PER_LINE - 1);

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   line_addr;
  logic [IDX_W-1:0]        beat_cnt;
  logic                    req_valid_q;
  logic                    rep_en_q;
  logic [1:0]              pc_src_q;

  logic                    miss_now;
  logic                    beat;
  logic                    last_beat;
  logic                    capture;
  logic [ADDR_WIDTH-1:0]   pc_line;

  assign pc_line   = pc_f_i & ~OFF_MASK;
  assign miss_now  = lookup_valid_i & ~lookup_hit_i;
  assign beat      = (state == FILL) & mem_rsp_valid_i;
  assign last_beat = beat & (beat_cnt == LAST_IDX);
  assign capture   = ((state == REQ) || (state == FILL)) &&
                     (pc_src_i != 2'b00) && (pc_src_q == 2'b00);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state       <= IDLE;
      line_addr   <= '0;
      beat_cnt    <= '0;
      req_valid_q <= 1'b0;
      rep_en_q    <= 1'b0;
      pc_src_q    <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          if (miss_now) begin
            line_addr   <= pc_line;
            req_valid_q <= 1'b1;
            state       <= REQ;
          end
        end
        REQ: begin
          if (mem_req_ready_i) begin
            req_valid_q <= 1'b0;
            beat_cnt    <= '0;
            state       <= FILL;
          end
        end
        FILL: begin
          if (beat) beat_cnt <= beat_cnt + 1'b1;
          if (last_beat) begin
            rep_en_q <= 1'b1;
            state    <= DONE;
          end
        end
        DONE: begin
          rep_en_q <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          req_valid_q <= 1'b0;
          rep_en_q    <= 1'b0;
          state       <= IDLE;
        end
      endcase

      // The line is installed regardless of a redirect, so the captured value
      // is dropped as the fill completes; completion overrides a late capture.
      if (last_beat)    pc_src_q <= 2'b00;
      else if (capture) pc_src_q <= pc_src_i;
    end
  end

  assign instr_miss_f_o       = (state == IDLE) ? miss_now : 1'b1;
  assign instr_cache_rep_en_o = rep_en_q;
  assign pc_src_reg_o         = pc_src_q;
  assign mem_req_valid_o      = req_valid_q;
  assign mem_req_addr_o       = line_addr;
  assign fill_we_o            = beat;
  assign fill_word_idx_o      = beat_cnt;
  assign fill_data_o          = beat ? mem_rsp_data_i : '0;
  assign fill_line_addr_o     = line_addr;

endmodule

// File: tb/tb_icache_miss_ctrl.sv
// Bench for icache_miss_ctrl: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a transaction-level model.
module tb_icache_miss_ctrl;
  localparam int W          = 4;
  localparam int AW         = 32;
  localparam int DW         = 32;
  localparam int LINE_BYTES = W * DW / 8;

  logic          clk_i = 1'b0;
  logic          reset_n_i;
  logic [AW-1:0] pc_f_i;
  logic          lookup_valid_i, lookup_hit_i;
  logic [1:0]    pc_src_i;
  logic          instr_miss_f_o, instr_cache_rep_en_o;
  logic [1:0]    pc_src_reg_o;
  logic          mem_req_valid_o, mem_req_ready_i;
  logic [AW-1:0] mem_req_addr_o;
  logic          mem_rsp_valid_i;
  logic [DW-1:0] mem_rsp_data_i;
  logic          fill_we_o;
  logic [1:0]    fill_word_idx_o;
  logic [DW-1:0] fill_data_o;
  logic [AW-1:0] fill_line_addr_o;

  int checks = 0;
  int errors = 0;
  int rep_seen = 0;

  icache_miss_ctrl #(.WORDS_PER_LINE(W), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .pc_f_i(pc_f_i),
    .lookup_valid_i(lookup_valid_i), .lookup_hit_i(lookup_hit_i), .pc_src_i(pc_src_i),
    .instr_miss_f_o(instr_miss_f_o), .instr_cache_rep_en_o(instr_cache_rep_en_o),
    .pc_src_reg_o(pc_src_reg_o), .mem_req_valid_o(mem_req_valid_o),
    .mem_req_ready_i(mem_req_ready_i), .mem_req_addr_o(mem_req_addr_o),
    .mem_rsp_valid_i(mem_rsp_valid_i), .mem_rsp_data_i(mem_rsp_data_i),
    .fill_we_o(fill_we_o), .fill_word_idx_o(fill_word_idx_o), .fill_data_o(fill_data_o),
    .fill_line_addr_o(fill_line_addr_o));

  always #5 clk_i = ~clk_i;

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: one outstanding line fill at a time.
  bit          m_busy, m_acc, m_rep;
  int          m_beats;
  logic [AW-1:0] m_line;
  logic [1:0]  m_redir;

  always @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      m_busy = 0; m_acc = 0; m_rep = 0; m_beats = 0; m_line = '0; m_redir = 2'b00;
    end else if (m_rep) begin
      m_rep = 0;
    end else if (!m_busy) begin
      if (lookup_valid_i && !lookup_hit_i) begin
        m_busy = 1; m_acc = 0;
        m_line = pc_f_i - (pc_f_i % LINE_BYTES);
      end
    end else begin
      if (pc_src_i != 2'b00 && m_redir == 2'b00) m_redir = pc_src_i;
      if (!m_acc) begin
        if (mem_req_ready_i) begin m_acc = 1; m_beats = 0; end
      end else if (mem_rsp_valid_i) begin
        m_beats = m_beats + 1;
        if (m_beats == W) begin m_busy = 0; m_acc = 0; m_rep = 1; m_redir = 2'b00; end
      end
    end
  end

  always @(negedge clk_i) begin
    if (reset_n_i) begin
      logic e_we;
      e_we = m_busy && m_acc && mem_rsp_valid_i;
      cmp("m_miss", instr_miss_f_o, (m_busy || m_rep) ? 1'b1 : (lookup_valid_i & ~lookup_hit_i));
      cmp("m_req_valid", mem_req_valid_o, m_busy && !m_acc);
      cmp("m_fill_we", fill_we_o, e_we);
      cmp("m_rep_en", instr_cache_rep_en_o, m_rep);
      cmp("m_pc_src_reg", pc_src_reg_o, m_redir);
      if (m_busy && !m_acc) cmp("m_req_addr", mem_req_addr_o, m_line);
      if (e_we) begin
        cmp("m_fill_idx", fill_word_idx_o, m_beats[1:0]);
        cmp("m_fill_data", fill_data_o, mem_rsp_data_i);
      end
      if ((m_busy && m_acc) || m_rep) cmp("m_fill_line", fill_line_addr_o, m_line);
      if (instr_cache_rep_en_o) rep_seen++;
    end
  end

  task automatic tick();
    @(posedge clk_i); #1;
  endtask

  task automatic idle_inputs();
    lookup_valid_i = 0; lookup_hit_i = 0; pc_src_i = 0;
    mem_req_ready_i = 0; mem_rsp_valid_i = 0; mem_rsp_data_i = '0;
  endtask

  initial begin
    int rep_before;
    reset_n_i = 0; pc_f_i = '0;
    idle_inputs();
    repeat (3) tick();
    reset_n_i = 1;
    #1;
    cmp("rst_miss", instr_miss_f_o, 0);
    cmp("rst_req_valid", mem_req_valid_o, 0);
    cmp("rst_rep_en", instr_cache_rep_en_o, 0);
    cmp("rst_pc_src_reg", pc_src_reg_o, 0);
    cmp("rst_req_addr", mem_req_addr_o, 0);

    // Hit path
    for (int i = 0; i < 10; i++) begin
      tick();
      pc_f_i = 32'h100 + 4 * i; lookup_valid_i = 1; lookup_hit_i = 1;
      #1;
      cmp("hit_miss", instr_miss_f_o, 0);
      cmp("hit_req", mem_req_valid_o, 0);
      cmp("hit_rep", instr_cache_rep_en_o, 0);
    end

    // Basic miss
    tick();
    pc_f_i = 32'h0000_1234; lookup_valid_i = 1; lookup_hit_i = 0;
    #1;
    cmp("basic_miss_comb", instr_miss_f_o, 1);
    cmp("basic_no_req_yet", mem_req_valid_o, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      lookup_valid_i = 0; mem_req_ready_i = 0;
      #1;
      cmp("basic_req_valid", mem_req_valid_o, 1);
      cmp("basic_req_addr", mem_req_addr_o, 32'h0000_1230);
      cmp("basic_miss_req", instr_miss_f_o, 1);
    end
    tick();
    mem_req_ready_i = 1;
    #1;
    cmp("basic_req_addr_hs", mem_req_addr_o, 32'h0000_1230);
    tick();
    mem_req_ready_i = 0;
    for (int i = 0; i < 4; i++) begin
      mem_rsp_valid_i = 1; mem_rsp_data_i = 32'hA0 + i;
      #1;
      cmp("basic_we", fill_we_o, 1);
      cmp("basic_idx", fill_word_idx_o, i[1:0]);
      cmp("basic_data", fill_data_o, 32'hA0 + i);
      cmp("basic_rep_early", instr_cache_rep_en_o, 0);
      tick();
    end
    mem_rsp_valid_i = 0;
    #1;
    cmp("basic_rep_done", instr_cache_rep_en_o, 1);
    cmp("basic_miss_done", instr_miss_f_o, 1);
    cmp("basic_line_done", fill_line_addr_o, 32'h0000_1230);
    tick();
    cmp("basic_rep_once", instr_cache_rep_en_o, 0);
    cmp("basic_miss_clear", instr_miss_f_o, 0);

    // Gapped beats with a redirect during the fill
    tick();
    pc_f_i = 32'h0000_3348; lookup_valid_i = 1; lookup_hit_i = 0;
    tick();
    lookup_valid_i = 0; mem_req_ready_i = 1;
    #1;
    cmp("gap_req_addr", mem_req_addr_o, 32'h0000_3340);
    tick();
    mem_req_ready_i = 0;
    for (int i = 0; i < 4; i++) begin
      pc_src_i = 0; mem_rsp_valid_i = 1; mem_rsp_data_i = 32'hB0 + i;
      #1;
      cmp("gap_we", fill_we_o, 1);
      cmp("gap_idx", fill_word_idx_o, i[1:0]);
      if (i >= 1) cmp("redir_held", pc_src_reg_o, 2'b11);
      tick();
      if (i < 3) begin
        mem_rsp_valid_i = 0;
        pc_src_i = (i == 0) ? 2'b11 : ((i == 2) ? 2'b01 : 2'b00);
        #1;
        cmp("gap_we_idle", fill_we_o, 0);
        cmp("gap_no_rep", instr_cache_rep_en_o, 0);
        tick();
      end
    end
    mem_rsp_valid_i = 0; pc_src_i = 0;
    #1;
    cmp("redir_rep", instr_cache_rep_en_o, 1);
    cmp("redir_clear_done", pc_src_reg_o, 2'b00);
    tick();

    // Back-to-back: redirected PC misses right after DONE
    pc_f_i = 32'h0000_2000; lookup_valid_i = 1; lookup_hit_i = 0;
    #1;
    cmp("b2b_miss", instr_miss_f_o, 1);
    tick();
    lookup_valid_i = 0; mem_req_ready_i = 1;
    #1;
    cmp("b2b_req_valid", mem_req_valid_o, 1);
    cmp("b2b_req_addr", mem_req_addr_o, 32'h0000_2000);
    tick();
    mem_req_ready_i = 0;
    for (int i = 0; i < 4; i++) begin
      mem_rsp_valid_i = 1; mem_rsp_data_i = 32'hC0 + i;
      tick();
    end
    mem_rsp_valid_i = 0;
    #1;
    cmp("b2b_rep", instr_cache_rep_en_o, 1);
    cmp("b2b_line", fill_line_addr_o, 32'h0000_2000);
    tick();

    // Randomized traffic
    rep_before = rep_seen;
    for (int i = 0; i < 3000; i++) begin
      pc_f_i          = $urandom;
      lookup_valid_i  = $urandom_range(0, 1);
      lookup_hit_i    = ($urandom % 3 == 0);
      mem_req_ready_i = ($urandom % 3 != 0);
      mem_rsp_valid_i = $urandom_range(0, 1);
      mem_rsp_data_i  = $urandom;
      pc_src_i        = ($urandom % 8 == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      tick();
    end
    checks++;
    if (rep_seen - rep_before < 50) begin
      errors++;
      $display("FAIL rand_progress got %0d fills expected at least 50", rep_seen - rep_before);
    end
    idle_inputs();
    repeat (8) tick();

    // Reset in the middle of a fill
    pc_f_i = 32'h0000_4000; lookup_valid_i = 1; lookup_hit_i = 0;
    tick();
    lookup_valid_i = 0; mem_req_ready_i = 1; pc_src_i = 2'b10;
    tick();
    mem_req_ready_i = 0; pc_src_i = 0;
    for (int i = 0; i < 2; i++) begin
      mem_rsp_valid_i = 1; mem_rsp_data_i = 32'hD0 + i;
      tick();
    end
    mem_rsp_valid_i = 1; mem_rsp_data_i = 32'h55;
    #1;
    cmp("pre_rst_pc_src_reg", pc_src_reg_o, 2'b10);
    cmp("pre_rst_we", fill_we_o, 1);
    #1 reset_n_i = 0;
    #1;
    cmp("arst_miss", instr_miss_f_o, 0);
    cmp("arst_req_valid", mem_req_valid_o, 0);
    cmp("arst_we", fill_we_o, 0);
    cmp("arst_rep", instr_cache_rep_en_o, 0);
    cmp("arst_pc_src_reg", pc_src_reg_o, 0);
    cmp("arst_idx", fill_word_idx_o, 0);
    cmp("arst_data", fill_data_o, 0);
    cmp("arst_line", fill_line_addr_o, 0);
    cmp("arst_req_addr", mem_req_addr_o, 0);
    tick();
    tick();
    reset_n_i = 1;
    for (int i = 0; i < 2; i++) begin
      mem_rsp_valid_i = 1; mem_rsp_data_i = 32'hE0 + i;
      #1;
      cmp("stray_we", fill_we_o, 0);
      cmp("stray_miss", instr_miss_f_o, 0);
      cmp("stray_req", mem_req_valid_o, 0);
      tick();
    end
    mem_rsp_valid_i = 0;
    #1;
    cmp("stray_no_rep", instr_cache_rep_en_o, 0);
    repeat (4) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
